// File: rtl/led_seq_monitor_pkg.sv
// Shared types and the thermometer-code helper for the LED sequence monitor.
package led_mon_pkg;

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        FILL     = 2'd1,
        DRAIN    = 2'd2
    } state_t;

    localparam int MAX_W = 32;

    typedef struct packed {
        logic       valid;
        logic [5:0] level;
    } therm_t;

    // Codes of the form (1<<k)-1 with k in 0..width are legal; level is k.
    function automatic therm_t is_therm(input logic [MAX_W-1:0] code, input int width);
        therm_t r;
        r = '0;
        for (int k = 0; k <= MAX_W; k++) begin
            if (k <= width && code == MAX_W'((64'd1 << k) - 64'd1)) begin
                r.valid = 1'b1;
                r.level = 6'(k);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/led_seq_monitor_if.sv
// LED bus observed by the monitor plus the monitor's decoded status outputs.
interface led_seq_monitor_if #(
    parameter int WIDTH         = 4,
    parameter int CNT_WIDTH     = 32,
    parameter int ERR_CNT_WIDTH = 8
);
    localparam int LW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0]         seq_in;
    logic [LW-1:0]            level;
    logic                     dir;
    logic                     locked;
    logic                     step_pulse;
    logic                     err_pulse;
    logic [ERR_CNT_WIDTH-1:0] err_count;
    logic                     stall;
    logic [CNT_WIDTH-1:0]     last_period;

    modport master (
        output seq_in,
        input  level, dir, locked, step_pulse, err_pulse, err_count, stall, last_period
    );

    modport slave (
        input  seq_in,
        output level, dir, locked, step_pulse, err_pulse, err_count, stall, last_period
    );

endinterface

// File: rtl/led_seq_monitor_therm_decode.sv
// Combinational thermometer decoder: LED code -> valid flag and fill level (0 when invalid).
module led_therm_decode
    import led_mon_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int LW    = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] i_seq,
    output logic             o_valid,
    output logic [LW-1:0]    o_level
);

    therm_t w_t;

    always_comb begin
        w_t     = is_therm(MAX_W'(i_seq), WIDTH);
        o_valid = w_t.valid;
        o_level = w_t.valid ? w_t.level[LW-1:0] : '0;
    end

endmodule

// File: rtl/led_seq_monitor.sv
// Receive-side checker for the thermometer fill/drain LED pattern.
// Define LED_MON_PERIOD_EN to enable the step-period measurement on last_period.
module led_seq_monitor
    import led_mon_pkg::*;
#(
    parameter int WIDTH          = 4,
    parameter int CNT_WIDTH      = 32,
    parameter int TIMEOUT_CYCLES = 100_000_000,
    parameter int ERR_CNT_WIDTH  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    led_seq_monitor_if.slave bus
);

    localparam int LW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0]         r_seq_q;
    state_t                   r_state;
    logic [LW-1:0]            r_level;
    logic                     r_dir;
    logic                     r_locked;
    logic                     r_step;
    logic                     r_err;
    logic                     r_stall;
    logic [ERR_CNT_WIDTH-1:0] r_err_cnt;
    logic [CNT_WIDTH-1:0]     r_timer;

    logic          w_valid;
    logic [LW-1:0] w_k;
    logic          w_change;
    logic          w_up;
    logic          w_dn;
    logic          w_turn_dn;
    logic          w_turn_up;
    logic          w_step;
    logic          w_err;

    led_therm_decode #(.WIDTH(WIDTH), .LW(LW)) u_dec (
        .i_seq   (bus.seq_in),
        .o_valid (w_valid),
        .o_level (w_k)
    );

    // Deltas are formed one bit wider so level+1 cannot alias back to 0.
    assign w_change  = (bus.seq_in != r_seq_q);
    assign w_up      = w_valid && ({1'b0, w_k} == {1'b0, r_level} + 1'b1);
    assign w_dn      = w_valid && ({1'b0, w_k} + 1'b1 == {1'b0, r_level});
    assign w_turn_dn = w_valid && (r_level == LW'(WIDTH)) && (w_k == LW'(WIDTH - 1));
    assign w_turn_up = w_valid && (r_level == '0) && (w_k == LW'(1));

    always_comb begin
        w_step = 1'b0;
        w_err  = 1'b0;
        if (w_change) begin
            case (r_state)
                UNLOCKED: w_err = !w_valid;
                FILL: begin
                    w_step = w_up || w_turn_dn;
                    w_err  = !w_step;
                end
                DRAIN: begin
                    w_step = w_dn || w_turn_up;
                    w_err  = !w_step;
                end
                default: w_err = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seq_q   <= '0;
            r_state   <= UNLOCKED;
            r_level   <= '0;
            r_dir     <= 1'b1;
            r_locked  <= 1'b0;
            r_step    <= 1'b0;
            r_err     <= 1'b0;
            r_stall   <= 1'b0;
            r_err_cnt <= '0;
            r_timer   <= '0;
        end else begin
            r_seq_q <= bus.seq_in;
            r_step  <= w_step;
            r_err   <= w_err;

            if (w_err && r_err_cnt != '1)
                r_err_cnt <= r_err_cnt + 1'b1;

            if (w_change) begin
                r_timer <= '0;
                r_stall <= 1'b0;
                r_level <= w_k;
                if (w_err) begin
                    r_state  <= UNLOCKED;
                    r_locked <= 1'b0;
                end else begin
                    case (r_state)
                        UNLOCKED: begin
                            if (w_up) begin
                                r_state  <= FILL;
                                r_dir    <= 1'b1;
                                r_locked <= 1'b1;
                            end else if (w_dn) begin
                                r_state  <= DRAIN;
                                r_dir    <= 1'b0;
                                r_locked <= 1'b1;
                            end
                        end
                        FILL: if (w_turn_dn) begin
                            r_state <= DRAIN;
                            r_dir   <= 1'b0;
                        end
                        DRAIN: if (w_turn_up) begin
                            r_state <= FILL;
                            r_dir   <= 1'b1;
                        end
                        default: begin
                            r_state  <= UNLOCKED;
                            r_locked <= 1'b0;
                        end
                    endcase
                end
            end else if (r_timer == CNT_WIDTH'(TIMEOUT_CYCLES - 1)) begin
                r_stall <= 1'b1;
            end else begin
                r_timer <= r_timer + 1'b1;
            end
        end
    end

`ifdef LED_MON_PERIOD_EN
    logic [CNT_WIDTH-1:0] r_period_cnt;
    logic [CNT_WIDTH-1:0] r_last_period;

    // The latched value counts the step cycle itself, hence the +1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_period_cnt  <= '0;
            r_last_period <= '0;
        end else if (w_step) begin
            r_period_cnt  <= '0;
            r_last_period <= (r_period_cnt == '1) ? r_period_cnt : r_period_cnt + 1'b1;
        end else if (r_period_cnt != '1) begin
            r_period_cnt <= r_period_cnt + 1'b1;
        end
    end

    assign bus.last_period = r_last_period;
`else
    assign bus.last_period = '0;
`endif

    assign bus.level      = r_level;
    assign bus.dir        = r_dir;
    assign bus.locked     = r_locked;
    assign bus.step_pulse = r_step;
    assign bus.err_pulse  = r_err;
    assign bus.err_count  = r_err_cnt;
    assign bus.stall      = r_stall;

endmodule
